// File: rtl/cert_chain_responder.sv
`default_nettype none
// ============================================================================
//  Module   : cert_chain_responder
//  Purpose  : Answers GET_CERTIFICATE requests by reading a window of a
//             certificate chain from byte-wide slot memory and returning it
//             as one response beat (header + payload + length).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset           rising-edge clock, synchronous active-high reset
//    Enable               responder enabled (low -> ERROR/Busy)
//    req_valid/req_ready  request handshake, req_msg = 64-bit request
//    slot_valid/slot_len  per-slot populated flag and chain length (16b/slot)
//    mem_rd_en/mem_addr   memory read port, mem_rd_data valid one cycle later
//    resp_valid/ready     response handshake
//    header/payload/resp_len  response contents, held until next decode
//    Ack_out              one-cycle pulse when a response is consumed
// ============================================================================
module cert_chain_responder #(
  parameter int SLOT_W      = 3,
  parameter int SLOT_AW     = 11,
  parameter int CHUNK_BYTES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        Enable,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [63:0]                 req_msg,
  input  logic [(2**SLOT_W)-1:0]      slot_valid,
  input  logic [(2**SLOT_W)*16-1:0]   slot_len,
  output logic                        mem_rd_en,
  output logic [SLOT_W+SLOT_AW-1:0]   mem_addr,
  input  logic [7:0]                  mem_rd_data,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [31:0]                 header,
  output logic [CHUNK_BYTES*8-1:0]    payload,
  output logic [15:0]                 resp_len,
  output logic                        Ack_out
);

  localparam int              c_ADDR_W     = SLOT_W + SLOT_AW;
  localparam logic [16:0]     c_SLOT_DEPTH = 17'(2**SLOT_AW);
  localparam logic [15:0]     c_CHUNK      = 16'(CHUNK_BYTES);
  localparam logic [c_ADDR_W-1:0] c_ADDR_ONE = {{(c_ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t       r_state;
  logic [7:0]   r_ver;
  logic [7:0]   r_type;
  logic [7:0]   r_slot;
  logic [15:0]  r_offset;
  logic [15:0]  r_length;
  logic         r_en;
  logic         r_slot_ok;     // slot in range and populated, sampled at accept
  logic [15:0]  r_slot_len;    // chain length of the addressed slot, sampled at accept
  logic [15:0]  r_n;
  logic [15:0]  r_idx;         // index of the read currently on the memory port
  logic         r_cap_vld;     // mem_rd_data carries the byte for r_cap_idx
  logic [15:0]  r_cap_idx;

  // Request fields that never influence the response.
  logic w_unused_param2;
  assign w_unused_param2 = &{1'b0, req_msg[31:24]};

  // Slot lookups happen at acceptance so later changes to the slot table
  // cannot disturb a request that is already in flight.
  logic [7:0]        w_in_slot;
  logic [SLOT_W-1:0] w_slot_idx;
  logic              w_slot_in_range;
  assign w_in_slot       = req_msg[23:16];
  assign w_slot_idx      = w_in_slot[SLOT_W-1:0];
  assign w_slot_in_range = ((w_in_slot >> SLOT_W) == 8'd0);

  // Effective chain length is clipped to the physical slot depth.
  logic [16:0] w_eff_len;
  logic [16:0] w_remain;
  logic [15:0] w_chunk_lim;
  logic [15:0] w_n;
  assign w_eff_len   = ({1'b0, r_slot_len} < c_SLOT_DEPTH) ? {1'b0, r_slot_len} : c_SLOT_DEPTH;
  assign w_remain    = w_eff_len - {1'b0, r_offset};
  assign w_chunk_lim = (r_length < c_CHUNK) ? r_length : c_CHUNK;
  assign w_n         = ({1'b0, w_chunk_lim} <= w_remain) ? w_chunk_lim : w_remain[15:0];

  // First matching check decides the error code; 0 means success.
  logic [7:0] w_err_code;
  always_comb begin
    w_err_code = 8'h00;
    if (!r_en)                                w_err_code = 8'h03;
    else if (r_ver != 8'h01)                  w_err_code = 8'h02;
    else if (r_type != 8'h82)                 w_err_code = 8'h01;
    else if (!r_slot_ok)                      w_err_code = 8'h01;
    else if ({1'b0, r_offset} >= w_eff_len)   w_err_code = 8'h01;
    else if (r_length == 16'd0)               w_err_code = 8'h01;
  end

  assign req_ready = (r_state == ST_IDLE) && !reset;
  assign Ack_out   = resp_valid && resp_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ver      <= 8'h00;
      r_type     <= 8'h00;
      r_slot     <= 8'h00;
      r_offset   <= 16'h0000;
      r_length   <= 16'h0000;
      r_en       <= 1'b0;
      r_slot_ok  <= 1'b0;
      r_slot_len <= 16'h0000;
      r_n        <= 16'h0000;
      r_idx      <= 16'h0000;
      r_cap_vld  <= 1'b0;
      r_cap_idx  <= 16'h0000;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      resp_valid <= 1'b0;
      header     <= 32'h0000_0000;
      payload    <= '0;
      resp_len   <= 16'h0000;
    end else begin
      // Land the byte returned for the previous cycle's read.
      if (r_cap_vld) begin
        for (int i = 0; i < CHUNK_BYTES; i++) begin
          if (r_cap_idx == 16'(i)) payload[8*i +: 8] <= mem_rd_data;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_ver      <= req_msg[7:0];
            r_type     <= req_msg[15:8];
            r_slot     <= req_msg[23:16];
            r_offset   <= req_msg[47:32];
            r_length   <= req_msg[63:48];
            r_en       <= Enable;
            r_slot_ok  <= w_slot_in_range && slot_valid[w_slot_idx];
            r_slot_len <= slot_len[{w_slot_idx, 4'b0000} +: 16];
            r_state    <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          payload <= '0;
          if (w_err_code != 8'h00) begin
            header     <= {8'h00, w_err_code, 8'h7F, 8'h01};
            resp_len   <= 16'h0000;
            resp_valid <= 1'b1;
            r_state    <= ST_RESP;
          end else begin
            header    <= {8'h00, r_slot, 8'h02, 8'h01};
            resp_len  <= w_n;
            r_n       <= w_n;
            r_idx     <= 16'h0000;
            mem_rd_en <= 1'b1;
            mem_addr  <= {r_slot[SLOT_W-1:0], r_offset[SLOT_AW-1:0]};
            r_state   <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          r_cap_vld <= 1'b1;
          r_cap_idx <= r_idx;
          if (r_idx == r_n - 16'd1) begin
            mem_rd_en <= 1'b0;
            r_state   <= ST_DRAIN;
          end else begin
            // The window never crosses the slot boundary, so the carry
            // cannot reach the slot field.
            r_idx    <= r_idx + 16'd1;
            mem_addr <= mem_addr + c_ADDR_ONE;
          end
        end

        ST_DRAIN: begin
          r_cap_vld  <= 1'b0;
          resp_valid <= 1'b1;
          r_state    <= ST_RESP;
        end

        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          mem_rd_en  <= 1'b0;
          resp_valid <= 1'b0;
          r_cap_vld  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cert_chain_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cert_chain_responder
//  Purpose  : Self-checking bench for cert_chain_responder: directed vector
//             table, multi-cycle corner sequences and randomized requests
//             checked against a behavioural response model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cert_chain_responder;

  localparam int SLOT_W  = 3;
  localparam int SLOT_AW = 11;
  localparam int CHUNK   = 64;
  localparam int NS      = 2**SLOT_W;
  localparam int AW      = SLOT_W + SLOT_AW;
  localparam int PW      = CHUNK * 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            Enable;
  logic            req_valid;
  logic            req_ready;
  logic [63:0]     req_msg;
  logic [NS-1:0]   slot_valid;
  logic [NS*16-1:0] slot_len;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [7:0]      mem_rd_data;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     header;
  logic [PW-1:0]   payload;
  logic [15:0]     resp_len;
  logic            Ack_out;

  cert_chain_responder #(
    .SLOT_W      (SLOT_W),
    .SLOT_AW     (SLOT_AW),
    .CHUNK_BYTES (CHUNK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Enable      (Enable),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_msg     (req_msg),
    .slot_valid  (slot_valid),
    .slot_len    (slot_len),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .header      (header),
    .payload     (payload),
    .resp_len    (resp_len),
    .Ack_out     (Ack_out)
  );

  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_mis    = 0;
  int mem_mode = 0;
  int rd_cnt   = 0;
  int ack_cnt  = 0;

  // Memory contents: mode 0 is the plain addr[7:0] pattern, mode 1 mixes in
  // the upper address bits so slot/offset errors become visible.
  function automatic logic [7:0] mem_byte(input int a);
    if (mem_mode == 0) return 8'(a);
    return 8'(a * 7 + (a >> 8) * 13 + 5);
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_byte(int'(mem_addr));
  always @(posedge clk) if (mem_rd_en) rd_cnt++;
  always @(posedge clk) if (Ack_out) ack_cnt++;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkpl(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int ver, input int typ, input int slot,
                                     input int off, input int len);
    return {16'(len), 16'(off), 8'h00, 8'(slot), 8'(typ), 8'(ver)};
  endfunction

  // Behavioural model: decides the response directly from the request
  // rules and the slot table captured when the request is issued.
  task automatic model(input logic [63:0] m, input logic en, input logic [NS-1:0] sv,
                       input logic [NS*16-1:0] sl, output logic [31:0] hdr,
                       output int len, output logic [PW-1:0] pl, output int lat);
    int ver, typ, slot, off, ln, eff, code, n;
    ver  = int'(m[7:0]);
    typ  = int'(m[15:8]);
    slot = int'(m[23:16]);
    off  = int'(m[47:32]);
    ln   = int'(m[63:48]);
    code = 0;
    eff  = 0;
    if (!en)               code = 3;
    else if (ver != 1)     code = 2;
    else if (typ != 'h82)  code = 1;
    else if (slot >= NS)   code = 1;
    else if (!sv[slot])    code = 1;
    else begin
      eff = int'(sl[slot*16 +: 16]);
      if (eff > (1 << SLOT_AW)) eff = 1 << SLOT_AW;
      if (off >= eff)      code = 1;
      else if (ln == 0)    code = 1;
    end
    pl = '0;
    if (code != 0) begin
      hdr = {8'h00, 8'(code), 8'h7F, 8'h01};
      len = 0;
      lat = 2;
    end else begin
      n = ln;
      if (n > CHUNK) n = CHUNK;
      if (n > eff - off) n = eff - off;
      hdr = {8'h00, 8'(slot), 8'h02, 8'h01};
      len = n;
      lat = 3 + n;
      for (int i = 0; i < n; i++) pl[i*8 +: 8] = mem_byte(slot * (1 << SLOT_AW) + off + i);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  // One complete transaction: issue, time the response, check it, apply
  // optional backpressure, consume it and check the acknowledge.
  task automatic run_req(input string nm, input logic [63:0] m, input logic en,
                         input int hold, input bit perturb, input logic [31:0] e_hdr,
                         input int e_len, input logic [PW-1:0] e_pl, input int e_lat);
    int cyc;
    bit ok;
    logic [NS-1:0]    sv_s;
    logic [NS*16-1:0] sl_s;
    cyc = 0;
    while (!req_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    if (!req_ready) begin chk32({nm, "_req_ready_timeout"}, 32'd0, 32'd1); return; end
    Enable    = en;
    req_msg   = m;
    req_valid = 1'b1;
    rd_cnt    = 0;
    ack_cnt   = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_msg   = {$urandom, $urandom};
    sv_s = slot_valid;
    sl_s = slot_len;
    if (perturb) begin
      Enable     = ~en;
      slot_valid = '0;
      slot_len   = '0;
    end
    cyc = 1;
    while (!resp_valid && cyc < 400) begin @(posedge clk); #1; cyc++; end
    Enable     = en;
    slot_valid = sv_s;
    slot_len   = sl_s;
    if (!resp_valid) begin
      chk32({nm, "_resp_timeout"}, 32'd0, 32'd1);
      pulse_reset();
      return;
    end
    chk32({nm, "_latency"}, 32'(cyc), 32'(e_lat));
    chk32({nm, "_header"}, header, e_hdr);
    chk32({nm, "_resp_len"}, 32'(resp_len), 32'(e_len));
    chkpl({nm, "_payload"}, payload, e_pl);
    chk32({nm, "_mem_reads"}, 32'(rd_cnt), 32'(e_len));
    ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      resp_ready = 1'b0;
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || header !== e_hdr || resp_len !== 16'(e_len) ||
          payload !== e_pl || req_ready !== 1'b0 || Ack_out !== 1'b0) ok = 1'b0;
    end
    if (hold > 0) chk32({nm, "_hold_stable"}, 32'(ok), 32'd1);
    resp_ready = 1'b1;
    #1;
    chk32({nm, "_ack_now"}, 32'(Ack_out), 32'd1);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk32({nm, "_ack_count"}, 32'(ack_cnt), 32'd1);
    chk32({nm, "_idle_after"}, 32'({resp_valid, req_ready}), 32'd1);
    chk32({nm, "_hdr_held"}, header, e_hdr);
  endtask

  typedef struct {
    string       nm;
    logic [63:0] msg;
    logic        en;
    logic [31:0] hdr;
    int          len;
    int          b0;    // payload byte 0 value; byte i = b0 + i
    int          lat;
    int          hold;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t             tbl[10];
    logic [PW-1:0]    e_pl;
    logic [31:0]      m_hdr;
    int               m_len, m_lat, cyc;
    bit               ok;
    logic [63:0]      m;
    logic             en;

    reset      = 1'b1;
    Enable     = 1'b1;
    req_valid  = 1'b0;
    req_msg    = '0;
    resp_ready = 1'b0;
    slot_valid = 8'b0000_0100;
    slot_len   = '0;
    slot_len[2*16 +: 16] = 16'd1000;
    slot_len[5*16 +: 16] = 16'd500;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk32("rst_ctrl", 32'({req_ready, resp_valid, Ack_out, mem_rd_en}), 32'd0);
    chk32("rst_addr", 32'(mem_addr), 32'd0);
    chk32("rst_hdr", header, 32'd0);
    chk32("rst_len", 32'(resp_len), 32'd0);
    chkpl("rst_payload", payload, '0);
    reset = 1'b0;
    #1;
    chk32("rst_release_ready", 32'(req_ready), 32'd1);

    tbl[0] = '{"ok_20",       mk(1, 'h82, 2,   10,  20), 1'b1, 32'h0002_0201, 20,  10,  23, 0};
    tbl[1] = '{"end_clamp",   mk(1, 'h82, 2,  990, 100), 1'b1, 32'h0002_0201, 10, 222,  13, 0};
    tbl[2] = '{"chunk_clamp", mk(1, 'h82, 2,    0, 300), 1'b1, 32'h0002_0201, 64,   0,  67, 10};
    tbl[3] = '{"bad_ver",     mk(2, 'h82, 2,   10,  20), 1'b1, 32'h0002_7F01,  0,   0,   2, 0};
    tbl[4] = '{"bad_slot5",   mk(1, 'h82, 5,   10,  20), 1'b1, 32'h0001_7F01,  0,   0,   2, 0};
    tbl[5] = '{"off_1000",    mk(1, 'h82, 2, 1000,  20), 1'b1, 32'h0001_7F01,  0,   0,   2, 0};
    tbl[6] = '{"len_0",       mk(1, 'h82, 2,   10,   0), 1'b1, 32'h0001_7F01,  0,   0,   2, 3};
    tbl[7] = '{"disabled",    mk(1, 'h82, 2,   10,  20), 1'b0, 32'h0003_7F01,  0,   0,   2, 0};
    tbl[8] = '{"bad_type",    mk(1, 'h83, 2,   10,  20), 1'b1, 32'h0001_7F01,  0,   0,   2, 0};
    tbl[9] = '{"last_byte",   mk(1, 'h82, 2,  999,   5), 1'b1, 32'h0002_0201,  1, 231,   4, 0};

    mem_mode = 0;
    for (int v = 0; v < 10; v++) begin
      e_pl = '0;
      for (int i = 0; i < tbl[v].len; i++) e_pl[i*8 +: 8] = 8'(tbl[v].b0 + i);
      run_req(tbl[v].nm, tbl[v].msg, tbl[v].en, tbl[v].hold, 1'b0,
              tbl[v].hdr, tbl[v].len, e_pl, tbl[v].lat);
    end

    // Slot table and Enable change right after acceptance.
    m = mk(1, 'h82, 2, 100, 8);
    model(m, 1'b1, slot_valid, slot_len, m_hdr, m_len, e_pl, m_lat);
    run_req("perturb", m, 1'b1, 1, 1'b1, m_hdr, m_len, e_pl, m_lat);

    // Reset while the fetch is in progress.
    Enable    = 1'b1;
    req_msg   = mk(1, 'h82, 2, 0, 64);
    req_valid = 1'b1;
    ack_cnt   = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (!mem_rd_en && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk32("midfetch_started", 32'(mem_rd_en), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk32("midfetch_rst_ctrl", 32'({req_ready, resp_valid, Ack_out, mem_rd_en}), 32'd0);
    chk32("midfetch_rst_hdr", header, 32'd0);
    chkpl("midfetch_rst_payload", payload, '0);
    reset = 1'b0;
    #1;
    chk32("midfetch_ready", 32'(req_ready), 32'd1);
    ok = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0 || mem_rd_en !== 1'b0) ok = 1'b0;
    end
    chk32("midfetch_no_resp", 32'(ok), 32'd1);
    chk32("midfetch_no_ack", 32'(ack_cnt), 32'd0);
    e_pl = '0;
    for (int i = 0; i < 20; i++) e_pl[i*8 +: 8] = 8'(10 + i);
    run_req("after_reset", mk(1, 'h82, 2, 10, 20), 1'b1, 0, 1'b0,
            32'h0002_0201, 20, e_pl, 23);

    // Randomized requests against the model.
    mem_mode = 1;
    for (int r = 0; r < 40; r++) begin
      int slot, off, ln, sl;
      slot_valid = 8'($urandom);
      for (int s = 0; s < NS; s++) slot_len[s*16 +: 16] = 16'($urandom_range(0, 2600));
      en   = ($urandom_range(0, 9) != 0);
      slot = $urandom_range(0, 9);
      sl   = (slot < NS) ? int'(slot_len[slot*16 +: 16]) : 2000;
      if (sl > 2048) sl = 2048;
      off  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, sl + 3);
      ln   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 300) : $urandom_range(1, 70);
      m = mk(($urandom_range(0, 9) == 0) ? 2 : 1,
             ($urandom_range(0, 9) == 0) ? 'h84 : 'h82, slot, off, ln);
      model(m, en, slot_valid, slot_len, m_hdr, m_len, e_pl, m_lat);
      run_req("rand", m, en, $urandom_range(0, 3), 1'b0, m_hdr, m_len, e_pl, m_lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cert_chain_responder.md
CERT_CHAIN_RESPONDER -- requirements
Module: cert_chain_responder

Interface
REQ-001 SHALL have parameter SLOT_W, default 3, slot-ID field width; NUM_SLOTS = 2**SLOT_W.
REQ-002 SHALL have parameter SLOT_AW, default 11, per-slot certificate memory address width (slot depth 2**SLOT_AW bytes).
REQ-003 SHALL have parameter CHUNK_BYTES, default 64, maximum certificate bytes per response (1..256).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-005 Enable  in  1  responder enabled; low = answer every request with ERROR/Busy.
REQ-006 req_valid  in  1 / req_ready  out  1  request handshake.
REQ-007 req_msg  in  64  GET_CERTIFICATE request: [7:0] version, [15:8] type, [23:16] param1 (slot), [31:24] param2, [47:32] offset, [63:48] length (little-endian bytes).
REQ-008 slot_valid  in  NUM_SLOTS  per-slot populated flag.
REQ-009 slot_len  in  NUM_SLOTS*16  per-slot chain length in bytes, slot s at [16s+15:16s].
REQ-010 mem_rd_en  out  1 / mem_addr  out  SLOT_W+SLOT_AW / mem_rd_data  in  8  certificate memory port; data valid the cycle after mem_rd_en.
REQ-011 resp_valid  out  1 / resp_ready  in  1  response handshake.
REQ-012 header  out  32  response header, same byte layout as req_msg[31:0].
REQ-013 payload  out  CHUNK_BYTES*8  certificate bytes, byte i at [8i+7:8i].
REQ-014 resp_len  out  16  valid payload bytes.
REQ-015 Ack_out  out  1  one-cycle pulse when a response is consumed.

Function
REQ-016 FSM states IDLE, DECODE, FETCH, DRAIN, RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE: on req_valid&&req_ready, register req_msg and Enable, go DECODE.
REQ-018 DECODE checks, first match wins: Enable low -> ERROR 0x03; version != 0x01 -> ERROR 0x02; type != 0x82 -> ERROR 0x01; slot >= NUM_SLOTS or slot_valid[slot]=0 -> ERROR 0x01; offset >= eff_len -> ERROR 0x01; length = 0 -> ERROR 0x01.
REQ-019 eff_len = min(slot_len[slot], 2**SLOT_AW).
REQ-020 ERROR response: header = {0x00, code, 0x7F, 0x01} (param2, param1, type, version), resp_len = 0, payload = 0; DECODE -> RESP.
REQ-021 Success: N = min(length, CHUNK_BYTES, eff_len - offset), 16-bit unsigned arithmetic; DECODE -> FETCH; payload cleared.
REQ-022 FETCH issues N reads on consecutive cycles, mem_addr = {slot, offset[SLOT_AW-1:0] + idx}, idx = 0..N-1; no wrap possible by REQ-021.
REQ-023 Byte returned for idx k SHALL be written to payload byte k; bytes N..CHUNK_BYTES-1 stay 0.
REQ-024 After last issue go DRAIN (capture final byte), then RESP.
REQ-025 Success header = {0x00, slot, 0x02, 0x01}; resp_len = N.
REQ-026 Latency: acceptance at cycle T -> resp_valid at T+2 (error) or T+3+N (success).
REQ-027 RESP: resp_valid high, header/payload/resp_len stable until resp_ready; on resp_valid&&resp_ready pulse Ack_out for that cycle, go IDLE next cycle.
REQ-028 header/payload/resp_len SHALL hold last response values in IDLE until the next DECODE.
REQ-029 mem_rd_en high only in FETCH; Enable, slot_valid, slot_len changes after acceptance do not affect the in-flight request.

Reset
REQ-030 reset SHALL, at the clock edge, force IDLE, req_ready = 0 during reset and 1 the cycle after, resp_valid = 0, Ack_out = 0, mem_rd_en = 0, mem_addr = 0, header = 0, payload = 0, resp_len = 0.
REQ-031 reset in any state SHALL abandon the in-flight request with no response and no Ack_out.

Verification
REQ-032 Slot 2 valid, len 1000, memory byte = addr[7:0]; request v1 type 0x82 slot 2 offset 10 length 20 -> resp at T+23, header 0x00020201, resp_len 20, payload bytes = low byte of {2,10..29}.
REQ-033 Same slot, offset 990 length 100 -> resp_len 10 (chain-end clamp); offset 0 length 300 -> resp_len 64 (CHUNK clamp); bytes beyond resp_len zero.
REQ-034 Errors: version 0x02 -> header 0x0002_7F01; slot 5 invalid -> 0x00017F01; offset 1000 -> 0x00017F01; length 0 -> 0x00017F01; Enable low -> 0x00037F01; each at T+2, resp_len 0, no mem_rd_en.
REQ-035 Backpressure: hold resp_ready low 10 cycles -> outputs stable, req_ready 0, Ack_out pulses exactly once on the accepting cycle.
REQ-036 Assert reset mid-FETCH -> next cycle state IDLE, mem_rd_en 0, resp_valid 0, no Ack_out; following request answered correctly.
